// File: rtl/core_imm_enc.sv
`timescale 1ns/1ps
// Immediate encoder: writes a 32-bit immediate into the I/S/B/U/J fields of a
// base instruction through a two-stage valid/ready pipeline with error counting.
module core_imm_enc #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_inst_i,
    input  logic [31:0]          req_imm_i,
    input  logic                 req_sel_imm_i_i,
    input  logic                 req_sel_imm_s_i,
    input  logic                 req_sel_imm_b_i,
    input  logic                 req_sel_imm_u_i,
    input  logic                 req_sel_imm_j_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_inst_o,
    output logic                 rsp_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    input  logic                 err_cnt_clr_i
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NSEL  = 5;
    localparam int unsigned SEL_I = 0;
    localparam int unsigned SEL_S = 1;
    localparam int unsigned SEL_B = 2;
    localparam int unsigned SEL_U = 3;
    localparam int unsigned SEL_J = 4;

    logic            s1_valid;
    logic [XLEN-1:0] s1_inst;
    logic [XLEN-1:0] s1_imm;
    logic [NSEL-1:0] s1_sel;
    logic            s2_adv;
    logic [XLEN-1:0] enc_inst;
    logic            enc_err;
    logic            multi_sel;
    logic            sx11;
    logic            sx12;
    logic            sx20;
    logic            rsp_hs;

    // S2 can take new data when empty or draining this cycle; S1 likewise behind it.
    assign s2_adv      = !rsp_valid_o || rsp_ready_i;
    assign req_ready_o = !s1_valid || s2_adv;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_inst  <= '0;
            s1_imm   <= '0;
            s1_sel   <= '0;
        end else if (req_ready_o) begin
            s1_valid <= req_valid_i;
            if (req_valid_i) begin
                s1_inst <= req_inst_i;
                s1_imm  <= req_imm_i;
                s1_sel  <= {req_sel_imm_j_i, req_sel_imm_u_i, req_sel_imm_b_i,
                            req_sel_imm_s_i, req_sel_imm_i_i};
            end
        end
    end

    // Range checks: the upper bits must be a pure sign extension.
    assign sx11      = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign sx12      = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
    assign sx20      = (&s1_imm[31:20]) || !(|s1_imm[31:20]);
    assign multi_sel = |(s1_sel & (s1_sel - NSEL'(1)));

    always_comb begin
        enc_inst = s1_inst;
        enc_err  = 1'b0;
        if (s1_sel[SEL_I]) begin
            enc_inst[31:20] = s1_imm[11:0];
            enc_err         = !sx11;
        end else if (s1_sel[SEL_S]) begin
            enc_inst[31:25] = s1_imm[11:5];
            enc_inst[11:7]  = s1_imm[4:0];
            enc_err         = !sx11;
        end else if (s1_sel[SEL_B]) begin
            enc_inst[31]    = s1_imm[12];
            enc_inst[7]     = s1_imm[11];
            enc_inst[30:25] = s1_imm[10:5];
            enc_inst[11:8]  = s1_imm[4:1];
            enc_err         = s1_imm[0] || !sx12;
        end else if (s1_sel[SEL_U]) begin
            enc_inst[31:12] = s1_imm[31:12];
            enc_err         = |s1_imm[11:0];
        end else if (s1_sel[SEL_J]) begin
            enc_inst[31]    = s1_imm[20];
            enc_inst[19:12] = s1_imm[19:12];
            enc_inst[20]    = s1_imm[11];
            enc_inst[30:21] = s1_imm[10:1];
            enc_err         = s1_imm[0] || !sx20;
        end
        if (multi_sel) begin
            enc_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_inst_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else if (s2_adv) begin
            rsp_valid_o <= s1_valid;
            if (s1_valid) begin
                rsp_inst_o <= enc_inst;
                rsp_err_o  <= enc_err;
            end
        end
    end

    // Saturating count of error responses; clear takes precedence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (err_cnt_clr_i) begin
            err_cnt_o <= '0;
        end else if (rsp_hs && rsp_err_o && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_imm_enc.sv
`timescale 1ns/1ps
// Bench for core_imm_enc: directed vectors, backpressure, reset and counter
// cases, plus randomized traffic checked against a decode-based reference model.
module tb_core_imm_enc;

    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  sel;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_inst = '0;
    logic [31:0]   req_imm = '0;
    logic [4:0]    req_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_inst;
    logic          rsp_err;
    logic [CW-1:0] err_cnt;
    logic          err_cnt_clr = 1'b0;

    req_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    logic last_valid, last_ready, last_acc, last_hs, last_err;
    logic [31:0] last_inst, last_seen;

    always #5 clk = ~clk;

    core_imm_enc #(.ERR_CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_inst_i(req_inst), .req_imm_i(req_imm),
        .req_sel_imm_i_i(req_sel[0]), .req_sel_imm_s_i(req_sel[1]),
        .req_sel_imm_b_i(req_sel[2]), .req_sel_imm_u_i(req_sel[3]),
        .req_sel_imm_j_i(req_sel[4]),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_inst_o(rsp_inst), .rsp_err_o(rsp_err),
        .err_cnt_o(err_cnt), .err_cnt_clr_i(err_cnt_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Keep the low 'bits' bits of v and sign-extend them arithmetically.
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] lo, hb;
        lo = v & ((32'd1 << bits) - 32'd1);
        hb = 32'd1 << (bits - 1);
        return (lo ^ hb) - hb;
    endfunction

    function automatic logic [31:0] decode(input logic [31:0] x, input int f);
        case (f)
            0:       return sext({20'b0, x[31:20]}, 12);
            1:       return sext({20'b0, x[31:25], x[11:7]}, 12);
            2:       return sext({19'b0, x[31], x[7], x[30:25], x[11:8], 1'b0}, 13);
            3:       return {x[31:12], 12'b0};
            default: return sext({11'b0, x[31], x[19:12], x[20], x[30:21], 1'b0}, 21);
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input int f);
        case (f)
            0:       return 32'hFFF0_0000;
            1, 2:    return 32'hFE00_0F80;
            default: return 32'hFFFF_F000;
        endcase
    endfunction

    // Value a decoder must recover: the immediate wrapped to the format's range.
    function automatic logic [31:0] exp_dec(input logic [31:0] imm, input int f);
        case (f)
            0, 1:    return sext(imm, 12);
            2:       return sext(imm & ~32'd1, 13);
            3:       return imm & 32'hFFFF_F000;
            default: return sext(imm & ~32'd1, 21);
        endcase
    endfunction

    function automatic logic range_err(input logic [31:0] imm, input int f);
        int s;
        s = $signed(imm);
        case (f)
            0, 1:    return (s < -2048) || (s > 2047);
            2:       return imm[0] || (s < -4096) || (s > 4095);
            3:       return (imm % 32'd4096) != 32'd0;
            default: return imm[0] || (s < -1048576) || (s > 1048575);
        endcase
    endfunction

    task automatic check_rsp(output logic e_err);
        req_t e;
        int f, ones;
        e = sb.pop_front();
        f = 5;
        ones = 0;
        for (int i = 4; i >= 0; i--) if (e.sel[i]) begin f = i; ones++; end
        if (f == 5) begin
            e_err = 1'b0;
            check("rsp_inst_pass", rsp_inst, e.inst);
        end else begin
            e_err = (ones > 1) || range_err(e.imm, f);
            check("rsp_field", decode(rsp_inst, f), exp_dec(e.imm, f));
            check("rsp_other_bits", rsp_inst & ~field_mask(f), e.inst & ~field_mask(f));
        end
        check("rsp_err", rsp_err, e_err);
    endtask

    // One clock: drive at posedge+1, evaluate handshakes at negedge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] imm,
                         input logic [4:0] sel, input logic rdy, input logic clr);
        logic e_err;
        req_valid = v; req_inst = inst; req_imm = imm; req_sel = sel;
        rsp_ready = rdy; err_cnt_clr = clr;
        @(negedge clk);
        e_err = 1'b0;
        last_ready = req_ready;
        last_valid = rsp_valid;
        last_seen = rsp_inst;
        last_acc = rst_n && v && req_ready;
        last_hs = rst_n && rsp_valid && rdy;
        if (last_hs) begin
            last_inst = rsp_inst;
            last_err = rsp_err;
            if (sb.size() == 0) check("rsp_queue_nonempty", 32'(sb.size()), 32'd1);
            else check_rsp(e_err);
        end
        if (last_acc) sb.push_back('{inst, imm, sel});
        if (!rst_n || clr) exp_cnt = 0;
        else if (last_hs && e_err && exp_cnt < (1 << CW) - 1) exp_cnt++;
        @(posedge clk);
        #1;
        if (rst_n) check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] imm, input logic [4:0] sel);
        cycle(1'b1, inst, imm, sel, 1'b1, 1'b0);
        repeat (3) idle();
    endtask

    initial begin
        req_t  bp[4];
        req_t  r;
        int    idx, acc_n, hs_n, f;
        logic [31:0] held, imm;
        logic [4:0]  sel;

        // Asynchronous reset, no clock edge involved.
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_inst", rsp_inst, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_ready", req_ready, 1'b1);

        // I-type sign extension and two-edge latency.
        cycle(1'b1, 32'h0000_0093, 32'hFFFF_FFFF, 5'b00001, 1'b1, 1'b0);
        check("i_accept", last_acc, 1'b1);
        idle();
        check("lat_after_accept_edge", last_valid, 1'b0);
        idle();
        check("lat_second_edge", last_valid, 1'b1);
        check("i_sext_inst", last_inst, 32'hFFF0_0093);
        check("i_sext_err", last_err, 1'b0);
        idle();
        send(32'h0000_0093, 32'h0000_0800, 5'b00001);
        check("i_range_err", last_err, 1'b1);
        check("i_range_cnt", 32'(err_cnt), 32'd1);

        // B-type.
        send(32'h0000_0063, 32'hFFFF_F800, 5'b00100);
        check("b_inst", last_inst, 32'h8000_00E3);
        check("b_err", last_err, 1'b0);
        send(32'h0000_0063, 32'h0000_0003, 5'b00100);
        check("b_odd_err", last_err, 1'b1);
        send(32'h0000_0063, 32'h0000_0000, 5'b00101);
        check("multi_inst", last_inst, 32'h0000_0063);
        check("multi_err", last_err, 1'b1);

        // U-type.
        send(32'h0000_00B7, 32'h1234_5000, 5'b01000);
        check("u_inst", last_inst, 32'h1234_50B7);
        check("u_err", last_err, 1'b0);
        send(32'h0000_00B7, 32'h1234_5001, 5'b01000);
        check("u_low_inst", last_inst, 32'h1234_50B7);
        check("u_low_err", last_err, 1'b1);

        // J-type.
        send(32'h0000_00EF, 32'h0000_0800, 5'b10000);
        check("j_inst", last_inst, 32'h0010_00EF);
        check("j_err", last_err, 1'b0);
        send(32'h0000_00EF, 32'h0010_0000, 5'b10000);
        check("j_range_err", last_err, 1'b1);
        check("cnt_saturated", 32'(err_cnt), 32'd3);

        // Clear coincident with an error handshake wins.
        cycle(1'b1, 32'h0000_0093, 32'h0000_0800, 5'b00001, 1'b1, 1'b0);
        idle();
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
        check("clr_hs_same_cycle", last_hs, 1'b1);
        idle();
        check("clr_wins", 32'(err_cnt), 32'd0);

        // Backpressure: four requests, only two fit.
        for (int k = 0; k < 4; k++) bp[k] = '{32'h0000_0013, 32'(k * 7 + 1), 5'b00001};
        idx = 0; acc_n = 0; held = '0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, bp[idx].inst, bp[idx].imm, bp[idx].sel, 1'b0, 1'b0);
            if (last_acc) begin idx++; acc_n++; end
            if (k == 2) held = last_seen;
        end
        check("bp_accepted", 32'(acc_n), 32'd2);
        check("bp_ready_low", last_ready, 1'b0);
        check("bp_rsp_valid", last_valid, 1'b1);
        check("bp_rsp_stable", last_seen, held);
        hs_n = 0;
        for (int k = 0; k < 4; k++) begin
            r = (idx < 4) ? bp[idx] : '0;
            cycle(idx < 4, r.inst, r.imm, r.sel, 1'b1, 1'b0);
            if (last_acc) idx++;
            if (last_hs) hs_n++;
        end
        check("bp_all_sent", 32'(idx), 32'd4);
        check("bp_one_per_cycle", 32'(hs_n), 32'd4);
        repeat (3) idle();

        // Randomized legal round-trip, one request per cycle.
        for (int n = 0; n < 10000; n++) begin
            f = int'($urandom_range(0, 4));
            imm = $urandom;
            case (f)
                0, 1:    imm = sext(imm, 12);
                2:       imm = sext(imm & ~32'd1, 13);
                3:       imm = imm & 32'hFFFF_F000;
                default: imm = sext(imm & ~32'd1, 21);
            endcase
            cycle(1'b1, $urandom, imm, 5'(5'd1 << f), 1'b1, 1'b0);
        end

        // Randomized mixed traffic with backpressure, bad selects and clears.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 7))
                5:       sel = 5'b00000;
                6:       sel = 5'($urandom);
                default: sel = 5'(5'd1 << $urandom_range(0, 4));
            endcase
            imm = ($urandom_range(0, 1) != 0) ? $urandom : sext($urandom, 13);
            cycle($urandom_range(0, 3) != 0, $urandom, imm, sel,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        for (int n = 0; n < 6 && sb.size() != 0; n++) idle();
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with both stages full.
        cycle(1'b1, 32'h0000_0013, 32'h0000_0001, 5'b00001, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0013, 32'h0000_0002, 5'b00001, 1'b0, 1'b0);
        check("pre_rst_full", last_ready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        sb.delete();
        exp_cnt = 0;
        cycle(1'b1, 32'hDEAD_BEEF, 32'h0000_0009, 5'b00001, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1 check("post_rst_ready", req_ready, 1'b1);
        send(32'h0000_0013, 32'h0000_0005, 5'b00001);
        check("post_rst_first", last_inst, 32'h0050_0013);
        check("post_rst_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
